// File: rtl/hr_ctrl_pkg.sv
// hr_ctrl_pkg: shared state encoding and per-program address tables
package hr_ctrl_pkg;
  localparam int PC_WIDTH = 9;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DONE} state_t;
  localparam logic [PC_WIDTH-1:0] START_ADDR [4] = '{9'd0, 9'd100, 9'd200, 9'd0};
  localparam logic [PC_WIDTH-1:0] END_ADDR [4] = '{9'd99, 9'd199, 9'd299, 9'd299};
endpackage

// File: rtl/prog_addr_lut.sv
// prog_addr_lut: maps a program number to its start and end addresses
module prog_addr_lut #(
  parameter int PC_WIDTH = hr_ctrl_pkg::PC_WIDTH
) (
  input  logic [1:0]          prog,
  output logic [PC_WIDTH-1:0] start_addr,
  output logic [PC_WIDTH-1:0] end_addr
);
  import hr_ctrl_pkg::*;
  assign start_addr = PC_WIDTH'(START_ADDR[prog]);
  assign end_addr = PC_WIDTH'(END_ADDR[prog]);
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: clears the register file, loads the core PC, then supervises a run with a watchdog
module run_sequencer #(
  parameter int PC_WIDTH = hr_ctrl_pkg::PC_WIDTH,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Go,
  input  logic [1:0]          ProgSel,
  input  logic [PC_WIDTH-1:0] CpuPc,
  output logic                CpuStart,
  output logic [PC_WIDTH-1:0] LoadTarget,
  output logic                ClrEn,
  output logic [3:0]          ClrAddr,
  output logic                Busy,
  output logic                Done,
  output logic                Timeout,
  output logic [15:0]         CycleCount
);
  import hr_ctrl_pkg::*;
  state_t state, state_nxt;
  logic [1:0] prog;
  logic [3:0] clr_addr;
  logic [15:0] cycle_count;
  logic timeout;
  logic [PC_WIDTH-1:0] start_addr, end_addr;
  logic go_ok, end_hit, wdog_hit;
  logic [16:0] cnt_inc;

  prog_addr_lut #(.PC_WIDTH(PC_WIDTH)) u_lut (
    .prog(prog),
    .start_addr(start_addr),
    .end_addr(end_addr)
  );

  // state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  // next state and outputs; an end-address match beats the watchdog in the same cycle
  always_comb begin
    go_ok = Go && (state == IDLE || state == DONE);
    cnt_inc = {1'b0, cycle_count} + 17'd1;
    end_hit = state == RUN && CpuPc == end_addr;
    wdog_hit = state == RUN && int'(cnt_inc) >= WDOG_LIMIT;
    state_nxt = go_ok ? CLEAR :
                state == CLEAR ? (clr_addr == 4'd15 ? LOAD : CLEAR) :
                state == LOAD ? RUN :
                state == RUN ? (end_hit || wdog_hit ? DONE : RUN) : state;
    CpuStart = !Rst_n || state == CLEAR || state == LOAD;
    LoadTarget = start_addr;
    ClrEn = state == CLEAR;
    ClrAddr = clr_addr;
    Busy = state == CLEAR || state == LOAD || state == RUN;
    Done = state == DONE;
    Timeout = timeout;
    CycleCount = cycle_count;
  end

  // program latch, clear index, run-cycle counter and timeout flag
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prog <= 2'd0;
      clr_addr <= 4'd0;
      cycle_count <= 16'd0;
      timeout <= 1'b0;
    end else if (go_ok) begin
      prog <= ProgSel;
      clr_addr <= 4'd0;
      cycle_count <= 16'd0;
      timeout <= 1'b0;
    end else begin
      if (state == CLEAR) clr_addr <= clr_addr + 4'd1;
      if (state == RUN) begin
        cycle_count <= cnt_inc[16] ? cycle_count : cnt_inc[15:0];
        timeout <= wdog_hit && !end_hit;
      end
    end
  end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed scenarios checked against an elapsed-time model of the sequencer
module tb_run_sequencer;
  localparam int WDOG = 4096;
  logic Clk = 1'b0, Rst_n = 1'b1, Go = 1'b0;
  logic [1:0] ProgSel = 2'd0;
  logic [8:0] CpuPc = 9'd0;
  logic CpuStart, ClrEn, Busy, Done, Timeout;
  logic [8:0] LoadTarget;
  logic [3:0] ClrAddr;
  logic [15:0] CycleCount;
  int checks = 0, errors = 0;

  run_sequencer #(.PC_WIDTH(9), .WDOG_LIMIT(WDOG)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .ProgSel(ProgSel), .CpuPc(CpuPc),
    .CpuStart(CpuStart), .LoadTarget(LoadTarget), .ClrEn(ClrEn), .ClrAddr(ClrAddr),
    .Busy(Busy), .Done(Done), .Timeout(Timeout), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since Go was accepted; 0..15 clear, 16 load, 17+ run.
  bit m_active = 0, m_done = 0, m_to = 0;
  int m_t = 0, m_cnt = 0, m_prog = 0;

  function automatic int start_of(input int p);
    return p == 3 ? 0 : p * 100;
  endfunction
  function automatic int end_of(input int p);
    return p == 3 ? 299 : p * 100 + 99;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_active = 0; m_done = 0; m_to = 0; m_t = 0; m_cnt = 0; m_prog = 0;
    end else if (!m_active && Go) begin
      m_active = 1; m_done = 0; m_to = 0; m_t = 0; m_cnt = 0; m_prog = int'(ProgSel);
    end else if (m_active) begin
      if (m_t > 16) begin
        m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
        if (int'(CpuPc) == end_of(m_prog)) begin
          m_active = 0; m_done = 1; m_to = 0;
        end else if (m_cnt >= WDOG) begin
          m_active = 0; m_done = 1; m_to = 1;
        end
      end
      m_t++;
    end
  end

  always @(negedge Clk) begin
    chk("cpu_start", CpuStart, !Rst_n || (m_active && m_t <= 16));
    chk("load_target", LoadTarget, start_of(m_prog));
    chk("clr_en", ClrEn, m_active && m_t < 16);
    chk("clr_addr", ClrAddr, (m_active && m_t < 16) ? m_t : 0);
    chk("busy", Busy, m_active);
    chk("done", Done, m_done);
    chk("timeout", Timeout, m_to);
    chk("cycle_count", CycleCount, m_cnt);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic go(input logic [1:0] sel);
    Go = 1'b1;
    ProgSel = sel;
    tick();
    Go = 1'b0;
  endtask

  initial begin
    #1 Rst_n = 1'b0;
    #1 chk("rst_cpu_start", CpuStart, 1);
    chk("rst_busy", Busy, 0);
    tick(3);
    Rst_n = 1'b1;
    tick(3);
    chk("idle_hold", Busy, 0);
    go(2'd1);
    for (int i = 0; i < 16; i++) begin
      chk("clear_seq_en", ClrEn, 1);
      chk("clear_seq_addr", ClrAddr, i);
      tick();
    end
    chk("load_start", CpuStart, 1);
    chk("load_target_p1", LoadTarget, 100);
    tick();
    chk("run_busy", Busy, 1);
    chk("run_cpu_start", CpuStart, 0);
    tick(10);
    Go = 1'b1;
    ProgSel = 2'd2;
    tick();
    Go = 1'b0;
    chk("run_go_ignored_busy", Busy, 1);
    chk("run_go_ignored_target", LoadTarget, 100);
    tick(38);
    CpuPc = 9'd199;
    tick();
    CpuPc = 9'd0;
    chk("end_done", Done, 1);
    chk("end_timeout", Timeout, 0);
    chk("end_count", CycleCount, 50);
    tick(5);
    chk("done_hold_count", CycleCount, 50);
    go(2'd0);
    for (int i = 0; i < 5000 && !Done; i++) tick();
    chk("wdog_done", Done, 1);
    chk("wdog_timeout", Timeout, 1);
    chk("wdog_count", CycleCount, 4096);
    tick(2);
    go(2'd2);
    chk("restart_clears_timeout", Timeout, 0);
    tick(17 + 4095);
    CpuPc = 9'd299;
    tick();
    CpuPc = 9'd0;
    chk("tie_done", Done, 1);
    chk("tie_timeout", Timeout, 0);
    chk("tie_count", CycleCount, 4096);
    go(2'd3);
    tick(7);
    chk("pre_rst_addr", ClrAddr, 7);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_addr", ClrAddr, 0);
    chk("mid_rst_clr_en", ClrEn, 0);
    chk("mid_rst_cpu_start", CpuStart, 1);
    chk("mid_rst_target", LoadTarget, 0);
    tick(2);
    Rst_n = 1'b1;
    tick(4);
    chk("post_rst_idle", Busy, 0);
    chk("post_rst_no_done", Done, 0);
    go(2'd3);
    chk("restart_addr", ClrAddr, 0);
    chk("restart_en", ClrEn, 1);
    CpuPc = 9'd299;
    tick(20);
    chk("p3_done", Done, 1);
    chk("p3_count", CycleCount, 1);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 9, meaning program-counter width of the core.
REQ-002 The block SHALL have parameter WDOG_LIMIT, default 4096, meaning the maximum number of RUN cycles before the run is aborted.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port Go, input, 1, run request; accepted only in IDLE or DONE.
REQ-006 The block SHALL have port ProgSel, input, 2, program number; sampled on Go acceptance.
REQ-007 The block SHALL have port CpuPc, input, PC_WIDTH, the core's current program counter.
REQ-008 The block SHALL have port CpuStart, output, 1, holds the core PC at its load target while high.
REQ-009 The block SHALL have port LoadTarget, output, PC_WIDTH, start address for the selected program.
REQ-010 The block SHALL have port ClrEn, output, 1, register-file clear write strobe.
REQ-011 The block SHALL have port ClrAddr, output, 4, register index being cleared.
REQ-012 The block SHALL have port Busy, output, 1, high in CLEAR, LOAD and RUN.
REQ-013 The block SHALL have port Done, output, 1, high in DONE.
REQ-014 The block SHALL have port Timeout, output, 1, high in DONE when the run was aborted by the watchdog.
REQ-015 The block SHALL have port CycleCount, output, 16, number of RUN cycles of the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, LOAD, RUN and DONE.
REQ-017 In IDLE or DONE, Go=1 SHALL latch ProgSel, clear CycleCount and Timeout, and move to CLEAR next cycle.
REQ-018 CLEAR SHALL last exactly 16 cycles, with ClrEn=1 and ClrAddr stepping 0,1,...,15; the cycle after ClrAddr=15 SHALL be LOAD.
REQ-019 LOAD SHALL last exactly 1 cycle, with CpuStart=1 and LoadTarget equal to the start address of the latched program.
REQ-020 CpuStart SHALL also be 1 throughout CLEAR, and 0 in all other states.
REQ-021 In RUN, CycleCount SHALL increment by 1 per cycle and saturate at 16'hFFFF.
REQ-022 In RUN, CpuPc equal to the end address of the latched program SHALL move the FSM to DONE with Timeout=0.
REQ-023 In RUN, CycleCount reaching WDOG_LIMIT without an end-address match SHALL move the FSM to DONE with Timeout=1.
REQ-024 If the end-address match and the watchdog limit occur in the same cycle, the end match SHALL win, giving Timeout=0.
REQ-025 Go while Busy=1 SHALL be ignored, and ProgSel changes during a run SHALL have no effect.
REQ-026 DONE SHALL hold Done, Timeout and CycleCount stable until the next accepted Go.
REQ-027 LoadTarget SHALL be driven from the latched program in all states.

Reset
REQ-028 Rst_n=0 SHALL asynchronously force state IDLE and set the latched program to 0.
REQ-029 Rst_n=0 SHALL asynchronously force CpuStart=1, ClrEn=0, ClrAddr=0, Busy=0, Done=0, Timeout=0 and CycleCount=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no Done pulse.
REQ-031 After Rst_n deasserts, the block SHALL remain in IDLE until Go.

Structure
REQ-032 A shared package hr_ctrl_pkg SHALL hold the state enum, PC_WIDTH, and the 4-entry start-address and end-address constant tables.
REQ-033 Table values SHALL be: start = 0, 100, 200, 0; end = 99, 199, 299, 299.
REQ-034 A single combinational sub-module prog_addr_lut SHALL map the latched program to its start and end addresses.
REQ-035 Everything else SHALL live in run_sequencer.

Verification
REQ-036 Scenario: reset, then Go with ProgSel=1 -> 16 ClrEn cycles with ClrAddr 0..15, then LOAD with LoadTarget=100, then RUN.
REQ-037 Scenario: in RUN, drive CpuPc=199 after 50 RUN cycles -> Done=1, Timeout=0, CycleCount=50.
REQ-038 Scenario: with WDOG_LIMIT=4096 and CpuPc never reaching the end address -> Done=1, Timeout=1, CycleCount=4096.
REQ-039 Scenario: CpuPc equals the end address in the same cycle as CycleCount reaches the limit -> Timeout=0.
REQ-040 Scenario: Go and a ProgSel change during RUN -> no state change, and LoadTarget is unchanged.
REQ-041 Scenario: Rst_n=0 during CLEAR at ClrAddr=7 -> immediate IDLE with all outputs at reset values; a later Go restarts at ClrAddr=0.
